// File: rtl/instr_packer.sv
// instr_packer: packs decoded MIPS instruction fields into 32-bit R/I/J words and streams
// them with sequential byte addresses through a 2-entry output buffer. Each start command
// loads exactly DEPTH words.
//
// Optional feature macro: INSTR_PACKER_CHECK_EN enables the sticky fmt_err check for
// nonzero fields that the selected format does not use.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   start                      begins a run from IDLE or DONE
//   in_valid / in_ready        field-set handshake
//   opcode, rs_addr, rt_addr, rd_addr, func, imm, instr_index   decoded fields
//   out_valid / out_ready      packed-word handshake
//   out_data, out_addr         packed word and its byte address
//   busy, done, fmt_err        status
module instr_packer #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  rd_addr,
  input  logic [5:0]  func,
  input  logic [15:0] imm,
  input  logic [25:0] instr_index,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic        fmt_err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   acc_q, acc_d;
  logic [31:0]       next_addr_q, next_addr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wr_ptr_q, rd_ptr_q;
  logic [31:0]       data_q [2];
  logic [31:0]       addr_q [2];

  logic              accept, xfer, run_start;
  logic              is_r, is_j;
  logic [31:0]       word;

  assign is_r = (opcode == 6'h00);
  assign is_j = (opcode == 6'h02) || (opcode == 6'h03);

  always_comb begin
    word = {opcode, rs_addr, rt_addr, imm};
    if (is_r) begin
      word = {opcode, rs_addr, rt_addr, rd_addr, 5'b0, func};
    end else if (is_j) begin
      word = {opcode, instr_index};
    end
  end

  // in_ready comes from registered state only.
  assign in_ready  = (state_q == StRun) && (cnt_q < 2'd2) && (acc_q < CntW'(DEPTH));
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = data_q[rd_ptr_q];
  assign out_addr  = addr_q[rd_ptr_q];
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);

  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready;
  assign run_start = start && (state_q != StRun);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    next_addr_d = next_addr_q;
    cnt_d       = cnt_q;
    unique case ({accept, xfer})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          acc_d       = '0;
          next_addr_d = BASE_ADDR;
        end
      end
      StRun: begin
        if (accept) begin
          acc_d       = acc_q + CntW'(1);
          next_addr_d = next_addr_q + 32'd4;
        end
        // Look at next-cycle count so done rises the cycle after the final transfer.
        if ((acc_d == CntW'(DEPTH)) && (cnt_d == 2'd0)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      next_addr_q <= BASE_ADDR;
      cnt_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      data_q[0]   <= 32'd0;
      data_q[1]   <= 32'd0;
      addr_q[0]   <= 32'd0;
      addr_q[1]   <= 32'd0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      next_addr_q <= next_addr_d;
      cnt_q       <= cnt_d;
      if (accept) begin
        data_q[wr_ptr_q] <= word;
        addr_q[wr_ptr_q] <= next_addr_q;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

`ifdef INSTR_PACKER_CHECK_EN
  logic fmt_bad;
  logic fmt_err_q;

  always_comb begin
    fmt_bad = (rd_addr != 5'd0) || (func != 6'd0);
    if (is_r) begin
      fmt_bad = (imm[10:6] != 5'd0);
    end else if (is_j) begin
      fmt_bad = (rs_addr != 5'd0) || (rt_addr != 5'd0) || (rd_addr != 5'd0) ||
                (func != 6'd0) || (imm != 16'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_err_q <= 1'b0;
    end else if (run_start) begin
      fmt_err_q <= 1'b0;
    end else if (accept && fmt_bad) begin
      fmt_err_q <= 1'b1;
    end
  end

  assign fmt_err = fmt_err_q;
`else
  assign fmt_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_packer.sv
module tb_instr_packer;

  localparam logic [31:0] Base = 32'hFFFF_FFF8;
  localparam int unsigned Depth = 3;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready;
  logic [5:0]  opcode, func;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [15:0] imm;
  logic [25:0] instr_index;
  logic        out_valid, out_ready;
  logic [31:0] out_data, out_addr;
  logic        busy, done, fmt_err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] sb_q [$];
  logic [31:0] exp_addr;
  logic        exp_fmt;

  always #5 clk = ~clk;

  instr_packer #(.BASE_ADDR(Base), .DEPTH(Depth)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .func(func), .imm(imm), .instr_index(instr_index),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .busy(busy), .done(done), .fmt_err(fmt_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected {data, addr} per output transfer.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_word: got %h @ %h expected none", out_data, out_addr);
      end else begin
        e = sb_q.pop_front();
        check("out_data", out_data, e[63:32]);
        check("out_addr", out_addr, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    exp_addr = Base;
    tick();
    start = 1'b0;
  endtask

  // Offers one field set and waits (bounded) for acceptance.
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] im,
                      input logic [25:0] idx, input logic [31:0] exp_word, input bit push);
    bit ok = 0;
    opcode = op; rs_addr = rs; rt_addr = rt; rd_addr = rd; func = fn; imm = im;
    instr_index = idx;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        ok = 1;
        if (push) sb_q.push_back({exp_word, exp_addr});
        exp_addr = exp_addr + 32'd4;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept expected accept of %h", exp_word);
    end
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("done_reached", {31'd0, seen}, 32'd1);
    tick();
  endtask

  initial begin
`ifdef INSTR_PACKER_CHECK_EN
    exp_fmt = 1'b1;
`else
    exp_fmt = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rs_addr = '0; rt_addr = '0; rd_addr = '0; func = '0; imm = '0;
    instr_index = '0; exp_addr = Base;
    repeat (3) tick();
    rst = 1'b0;

    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_addr", out_addr, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fmt_err", {31'd0, fmt_err}, 32'd0);
    tick();

    // Run 1: R, I, J words with address wrap; exact latency and done timing.
    out_ready = 1'b1;
    do_start();
    @(negedge clk);
    check("start_in_ready", {31'd0, in_ready}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    tick();
    send(6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 32'h0022_1820, 1);
    @(negedge clk);
    check("latency_valid", {31'd0, out_valid}, 32'd1);
    tick();
    send(6'h08, 5'd4, 5'd5, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h2085_FFFF, 1);
    send(6'h02, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000010, 32'h0800_0010, 1);
    @(negedge clk);
    check("last_valid", {31'd0, out_valid}, 32'd1);
    check("done_early", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("done_timing", {31'd0, done}, 32'd1);
    check("done_drained", {31'd0, out_valid}, 32'd0);
    check("run1_fmt_err", {31'd0, fmt_err}, 32'd0);
    tick();
    // No further accepts once DEPTH words are loaded.
    in_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("no_4th_accept", {31'd0, in_ready}, 32'd0);
      tick();
    end
    in_valid = 1'b0;

    // Run 2: backpressure; first word also carries a format violation.
    out_ready = 1'b0;
    do_start();
    send(6'h08, 5'd1, 5'd2, 5'd0, 6'h01, 16'h1234, 26'h0, 32'h2022_1234, 1);
    send(6'h23, 5'd3, 5'd4, 5'd0, 6'h00, 16'h0008, 26'h0, 32'h8C64_0008, 1);
    in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("hold_data", out_data, 32'h2022_1234);
    tick();
    @(negedge clk);
    check("hold_data2", out_data, 32'h2022_1234);
    check("hold_addr2", out_addr, Base);
    check("fmt_err_set", {31'd0, fmt_err}, {31'd0, exp_fmt});
    tick();
    out_ready = 1'b1;
    send(6'h03, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FF_FFFF, 32'h0FFF_FFFF, 1);
    wait_done();
    check("fmt_err_sticky", {31'd0, fmt_err}, {31'd0, exp_fmt});

    // Run 3: next start clears fmt_err, then reset with a word buffered.
    out_ready = 1'b0;
    do_start();
    @(negedge clk);
    check("start_clears_fmt", {31'd0, fmt_err}, 32'd0);
    tick();
    send(6'h00, 5'd7, 5'd7, 5'd7, 6'h21, 16'h0000, 26'h0, 32'h00E7_3821, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    tick();

    // Run 4: restarts from BASE_ADDR.
    out_ready = 1'b1;
    do_start();
    send(6'h00, 5'd1, 5'd2, 5'd3, 6'h20, 16'h0000, 26'h0, 32'h0022_1820, 1);
    send(6'h08, 5'd4, 5'd5, 5'd0, 6'h00, 16'hFFFF, 26'h0, 32'h2085_FFFF, 1);
    send(6'h02, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000010, 32'h0800_0010, 1);
    wait_done();

    check("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
